memory_mapped_io_uart_rx: RTL and testbench
===========================================

// Module: memory_mapped_io_uart_rx
// PURPOSE
//  Memory-mapped UART receiver peripheral. Deserialises 8N1 frames from the uart_rx pin into a byte FIFO
//  and exposes data/status registers on the shared start/ready/rdata_valid bus used by the memory map
//  controller. The controller passes in an address already rebased to this block's window (offset 0).
// PARAMETERS
//  FMAX_MHz    27      core clock frequency in MHz
//  BAUD_RATE   115200  serial bit rate; CLKS_PER_BIT = FMAX_MHz*1_000_000/BAUD_RATE (integer div, 234 at defaults)
//  FIFO_DEPTH  16      receive FIFO entries, power of two, >=2
// PORTS
//  clk                 in   1   single clock, all logic on rising edge
//  rst_n               in   1   synchronous, active-low reset
//  uart_rx             in   1   asynchronous serial input, idle high
//  input_cmd_start     in   1   bus command strobe, sampled when output_cmd_ready=1
//  input_cmd_write     in   1   1=write, 0=read (qualified by start)
//  output_cmd_ready    out  1   block can accept a command this cycle
//  input_addr          in   32  byte offset within window
//  output_rdata        out  32  read data, valid only when output_rdata_valid=1
//  output_rdata_valid  out  1   one-cycle pulse carrying read response
//  input_wdata         in   32  write data
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge): receiver IDLE, FIFO empty, overflow/frame_err clear, output_rdata=0,
//   output_rdata_valid=0, output_cmd_ready=1. Reset mid-frame discards the partial byte.
//  Input sync: uart_rx through 2 flops before use; sync chain resets to 1.
//  Receiver FSM: IDLE -> START on synced 1->0; START waits CLKS_PER_BIT/2, line still 0 -> DATA else IDLE
//   (glitch). DATA samples 8 bits LSB first, one every CLKS_PER_BIT from start-bit centre. STOP samples after
//   CLKS_PER_BIT: 1 -> push byte; 0 -> discard, set frame_err. Then IDLE (new start edge may follow at once).
//  FIFO: push on good stop bit; if full, byte dropped and overflow set (sticky). Same-cycle push and pop
//   both take effect; count unchanged. Pointers wrap modulo FIFO_DEPTH.
//  Register map (input_addr[3:2]; [1:0] ignored):
//   0x0 DATA   read: [7:0]=FIFO head, [8]=1 if FIFO was non-empty, [31:9]=0; pops if non-empty.
//              Empty read returns 0, no pop.
//   0x4 STATUS read: [0]=non-empty, [1]=full, [2]=overflow, [3]=frame_err, [15:8]=count, rest 0.
//              Write: wdata[2]=1 clears overflow, wdata[3]=1 clears frame_err (W1C).
//   0x8,0xC    reads return 0, writes ignored.
//  Handshake: command accepted when start & ready. Read: rdata/rdata_valid registered, valid exactly 1 cycle
//   after acceptance; ready=0 that same cycle, 1 again the next. Write: completes in the acceptance cycle,
//   no rdata_valid pulse, ready stays 1. start while ready=0 is ignored.
//  Status read reflects state before any same-cycle push; W1C in same cycle as a new error: set wins.
// TESTING
//  Reset then read 0x4 -> rdata=0x00000000, valid 1 cycle after start, ready low that cycle only.
//  Drive frame 0x5A at 115200/27MHz, read 0x0 -> 0x0000015A; second read 0x0 -> 0x00000000.
//  Send 0x41,0x42,0x43 back-to-back, read 0x4 -> count=3 (0x00000301); three DATA reads -> 0x141,0x142,0x143.
//  Send 17 bytes with no reads -> STATUS 0x00001007 (count 16, full, overflow, non-empty); write 0x4=0x4 -> overflow clears.
//  Frame with stop bit 0 -> byte not queued, STATUS[3]=1; 1/4-bit low glitch on idle line -> nothing queued.
//  Assert rst_n=0 mid-frame after 4 data bits -> FIFO empty, next full frame 0x33 received cleanly.

Source files
------------

// File: rtl/memory_mapped_io_uart_rx.sv
// Memory-mapped 8N1 UART receiver: line synchroniser, receive FSM, byte FIFO and a
// DATA/STATUS register pair on the start/ready/rdata_valid command bus.
module memory_mapped_io_uart_rx #(
    parameter int unsigned FMAX_MHz   = 27,
    parameter int unsigned BAUD_RATE  = 115200,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        uart_rx,
    input  logic        input_cmd_start,
    input  logic        input_cmd_write,
    output logic        output_cmd_ready,
    input  logic [31:0] input_addr,
    output logic [31:0] output_rdata,
    output logic        output_rdata_valid,
    input  logic [31:0] input_wdata
);

    localparam int unsigned CLKS_PER_BIT = FMAX_MHz * 1_000_000 / BAUD_RATE;
    localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT + 1);
    localparam int unsigned PTR_W        = $clog2(FIFO_DEPTH);
    localparam int unsigned COUNT_W      = PTR_W + 1;

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} rx_state_e;

    // Line synchroniser plus one extra stage for falling-edge detection
    logic rx_meta_q, rx_sync_q, rx_prev_q;

    // Receiver state
    rx_state_e        state_q;
    logic [CNT_W-1:0] baud_cnt_q;
    logic [2:0]       bit_idx_q;
    logic [7:0]       shift_q;
    logic             rx_push_q;
    logic             rx_ferr_q;

    // FIFO state
    logic [7:0]         mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               overflow_q, overflow_d;
    logic               frame_err_q, frame_err_d;

    // Bus state
    logic        ready_q;
    logic        rvalid_q;
    logic [31:0] rdata_q, rdata_d;

    logic       empty, full, push, pop;
    logic       accept, rd_acc, wr_acc, wr_status;
    logic [1:0] addr_sel;
    logic [7:0] count8;
    logic       unused_bits;

    assign unused_bits = ^{input_addr[31:4], input_addr[1:0],
                           input_wdata[31:4], input_wdata[1:0]};

    // Two-flop synchroniser on the asynchronous serial input, idle-high reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= uart_rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    // Receive FSM: start-bit qualification at half bit, then sample every full bit period
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            rx_push_q  <= 1'b0;
            rx_ferr_q  <= 1'b0;
        end else begin
            rx_push_q <= 1'b0;
            rx_ferr_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    baud_cnt_q <= '0;
                    if (rx_prev_q && !rx_sync_q) begin
                        state_q <= StStart;
                    end
                end
                StStart: begin
                    if (baud_cnt_q == CNT_W'(HALF_BIT - 1)) begin
                        baud_cnt_q <= '0;
                        bit_idx_q  <= '0;
                        // A line back high at mid start bit is treated as a glitch
                        state_q    <= rx_sync_q ? StIdle : StData;
                    end else begin
                        baud_cnt_q <= baud_cnt_q + 1'b1;
                    end
                end
                StData: begin
                    if (baud_cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
                        baud_cnt_q <= '0;
                        shift_q    <= {rx_sync_q, shift_q[7:1]};
                        if (bit_idx_q == 3'd7) begin
                            state_q <= StStop;
                        end else begin
                            bit_idx_q <= bit_idx_q + 1'b1;
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q + 1'b1;
                    end
                end
                StStop: begin
                    if (baud_cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
                        baud_cnt_q <= '0;
                        state_q    <= StIdle;
                        rx_push_q  <= rx_sync_q;
                        rx_ferr_q  <= ~rx_sync_q;
                    end else begin
                        baud_cnt_q <= baud_cnt_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign empty     = (count_q == '0);
    assign full      = (count_q == COUNT_W'(FIFO_DEPTH));
    assign addr_sel  = input_addr[3:2];
    assign accept    = input_cmd_start & ready_q;
    assign rd_acc    = accept & ~input_cmd_write;
    assign wr_acc    = accept & input_cmd_write;
    assign wr_status = wr_acc & (addr_sel == 2'd1);
    assign push      = rx_push_q & ~full;
    assign pop       = rd_acc & (addr_sel == 2'd0) & ~empty;
    assign count8    = 8'(count_q);

    // FIFO occupancy and sticky error flags; a new error wins over a same-cycle clear
    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        overflow_d  = (overflow_q & ~(wr_status & input_wdata[2])) | (rx_push_q & full);
        frame_err_d = (frame_err_q & ~(wr_status & input_wdata[3])) | rx_ferr_q;
    end

    // Read data mux, built from pre-push state
    always_comb begin
        rdata_d = '0;
        unique case (addr_sel)
            2'd0: if (!empty) rdata_d = {23'b0, 1'b1, mem_q[rd_ptr_q]};
            2'd1: rdata_d = {16'b0, count8, 4'b0, frame_err_q, overflow_q, full, ~empty};
            default: rdata_d = '0;
        endcase
    end

    // FIFO storage, no reset needed since count gates every read
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= shift_q;
        end
    end

    // FIFO pointers, counters and error flags
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Bus handshake: reads answer one cycle later and block the bus for that cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ready_q  <= 1'b1;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            ready_q  <= ~rd_acc;
            rvalid_q <= rd_acc;
            if (rd_acc) rdata_q <= rdata_d;
        end
    end

    assign output_cmd_ready   = ready_q;
    assign output_rdata_valid = rvalid_q;
    assign output_rdata       = rdata_q;

endmodule

// File: tb/tb_memory_mapped_io_uart_rx.sv
// Directed bench for memory_mapped_io_uart_rx at 27 MHz / 115200 baud.
module tb_memory_mapped_io_uart_rx;

    localparam int CPB = 27 * 1_000_000 / 115200;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        uart_rx = 1'b1;
    logic        input_cmd_start = 1'b0;
    logic        input_cmd_write = 1'b0;
    logic        output_cmd_ready;
    logic [31:0] input_addr = '0;
    logic [31:0] output_rdata;
    logic        output_rdata_valid;
    logic [31:0] input_wdata = '0;

    int tests = 0;
    int fails = 0;

    memory_mapped_io_uart_rx #(
        .FMAX_MHz   (27),
        .BAUD_RATE  (115200),
        .FIFO_DEPTH (16)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .uart_rx            (uart_rx),
        .input_cmd_start    (input_cmd_start),
        .input_cmd_write    (input_cmd_write),
        .output_cmd_ready   (output_cmd_ready),
        .input_addr         (input_addr),
        .output_rdata       (output_rdata),
        .output_rdata_valid (output_rdata_valid),
        .input_wdata        (input_wdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = stop_bit;
        repeat (CPB) @(negedge clk);
        uart_rx = 1'b1;
    endtask

    task automatic bus_read(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        @(negedge clk);
        input_cmd_start = 1'b1;
        input_cmd_write = 1'b0;
        input_addr      = addr;
        check({tag, ".ready_pre"}, {31'b0, output_cmd_ready}, 32'd1);
        @(posedge clk);
        #1;
        check({tag, ".valid"}, {31'b0, output_rdata_valid}, 32'd1);
        check({tag, ".rdata"}, output_rdata, exp);
        check({tag, ".ready_low"}, {31'b0, output_cmd_ready}, 32'd0);
        @(negedge clk);
        input_cmd_start = 1'b0;
        @(posedge clk);
        #1;
        check({tag, ".valid_end"}, {31'b0, output_rdata_valid}, 32'd0);
        check({tag, ".ready_back"}, {31'b0, output_cmd_ready}, 32'd1);
    endtask

    task automatic bus_write(input string tag, input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        input_cmd_start = 1'b1;
        input_cmd_write = 1'b1;
        input_addr      = addr;
        input_wdata     = data;
        @(posedge clk);
        #1;
        check({tag, ".no_valid"}, {31'b0, output_rdata_valid}, 32'd0);
        check({tag, ".ready"}, {31'b0, output_cmd_ready}, 32'd1);
        @(negedge clk);
        input_cmd_start = 1'b0;
        input_cmd_write = 1'b0;
    endtask

    initial begin
        // Reset
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst.ready", {31'b0, output_cmd_ready}, 32'd1);
        check("rst.valid", {31'b0, output_rdata_valid}, 32'd0);
        check("rst.rdata", output_rdata, 32'h0);
        bus_read("rst.status", 32'h4, 32'h0000_0000);

        // Single frame
        send_frame(8'h5A, 1'b1);
        bus_read("one.data", 32'h0, 32'h0000_015A);
        bus_read("one.empty", 32'h0, 32'h0000_0000);

        // Three back-to-back frames
        send_frame(8'h41, 1'b1);
        send_frame(8'h42, 1'b1);
        send_frame(8'h43, 1'b1);
        bus_read("three.status", 32'h4, 32'h0000_0301);
        bus_read("three.d0", 32'h0, 32'h0000_0141);
        bus_read("three.d1", 32'h0, 32'h0000_0142);
        bus_read("three.d2", 32'h0, 32'h0000_0143);

        // Overflow: 17 frames into a 16-deep FIFO
        for (int i = 0; i < 17; i++) send_frame(8'(i), 1'b1);
        bus_read("ovf.status", 32'h4, 32'h0000_1007);
        bus_write("ovf.w1c", 32'h4, 32'h0000_0004);
        bus_read("ovf.cleared", 32'h4, 32'h0000_1003);
        for (int i = 0; i < 16; i++) bus_read("ovf.drain", 32'h0, 32'h100 | 32'(i));
        bus_read("ovf.empty", 32'h4, 32'h0000_0000);

        // Unmapped offsets
        bus_read("unmapped.8", 32'h8, 32'h0000_0000);
        bus_read("unmapped.c", 32'hC, 32'h0000_0000);

        // Framing error
        send_frame(8'h77, 1'b0);
        bus_read("ferr.status", 32'h4, 32'h0000_0008);
        bus_write("ferr.w1c", 32'h4, 32'h0000_0008);
        bus_read("ferr.cleared", 32'h4, 32'h0000_0000);

        // Quarter-bit glitch on idle line
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (CPB / 4) @(negedge clk);
        uart_rx = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        bus_read("glitch.status", 32'h4, 32'h0000_0000);

        // Reset in the middle of a frame after four data bits
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            uart_rx = i[0] ? 1'b0 : 1'b1;
            repeat (CPB) @(negedge clk);
        end
        rst_n   = 1'b0;
        uart_rx = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        bus_read("midrst.status", 32'h4, 32'h0000_0000);
        send_frame(8'h33, 1'b1);
        bus_read("midrst.data", 32'h0, 32'h0000_0133);
        bus_read("midrst.empty", 32'h4, 32'h0000_0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
